// File: rtl/led_pattern_gen.sv
// Parametrised LED pattern engine: binary count, bouncing scanner, PWM breathing and static pattern.
// Every output is registered so it can feed the LED output buffers directly.
module led_pattern_gen #(
   parameter int NUM_LEDS   = 8,
   parameter int CTR_WIDTH  = 26,
   parameter int TICK_SHIFT = 18,
   parameter int PWM_BITS   = 8,
   parameter int ACTIVE_LOW = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic                mode_we,
   input  logic [1:0]          mode_in,
   input  logic [NUM_LEDS-1:0] pattern,
   output logic [NUM_LEDS-1:0] leds,
   output logic                tick,
   output logic [1:0]          mode
);

   typedef enum logic [1:0] {
      MODE_COUNT   = 2'd0,
      MODE_SCAN    = 2'd1,
      MODE_BREATHE = 2'd2,
      MODE_STATIC  = 2'd3
   } mode_e;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

   localparam int POS_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
   localparam logic [POS_W-1:0]    POS_LAST = POS_W'(NUM_LEDS - 1);
   localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
   localparam logic [NUM_LEDS-1:0] LED_MASK = (ACTIVE_LOW != 0) ? '1 : '0;

   logic [CTR_WIDTH-1:0] ctr_q, ctr_d;
   mode_e                mode_q, mode_d;
   logic [POS_W-1:0]     pos_q, pos_d;
   logic [PWM_BITS-1:0]  duty_q, duty_d;
   dir_e                 dir_q, dir_d;
   logic [NUM_LEDS-1:0]  leds_d, led_next;
   logic [PWM_BITS-1:0]  pwm;
   logic                 tick_int;

   assign tick_int = en && (ctr_q[TICK_SHIFT-1:0] == '1);
   assign pwm      = ctr_q[PWM_BITS-1:0];
   assign mode     = mode_q;

   // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
   always_comb begin
      ctr_d    = ctr_q;
      mode_d   = mode_q;
      pos_d    = pos_q;
      dir_d    = dir_q;
      duty_d   = duty_q;
      leds_d   = leds;
      led_next = '0;

      if (en) ctr_d = ctr_q + 1'b1;

      case (mode_q)
         MODE_COUNT: led_next = ctr_q[CTR_WIDTH-1 -: NUM_LEDS];
         MODE_SCAN: begin
            led_next = NUM_LEDS'(1) << pos_q;
            if (tick_int && NUM_LEDS > 1) begin
               if (dir_q == DIR_UP) begin
                  if (pos_q == POS_LAST) begin
                     dir_d = DIR_DOWN;
                     pos_d = pos_q - 1'b1;
                  end else begin
                     pos_d = pos_q + 1'b1;
                  end
               end else begin
                  if (pos_q == '0) begin
                     dir_d = DIR_UP;
                     pos_d = pos_q + 1'b1;
                  end else begin
                     pos_d = pos_q - 1'b1;
                  end
               end
            end
         end
         MODE_BREATHE: begin
            led_next = {NUM_LEDS{pwm < duty_q}};
            if (tick_int) begin
               if (dir_q == DIR_UP) begin
                  if (duty_q == DUTY_MAX) begin
                     dir_d  = DIR_DOWN;
                     duty_d = duty_q - 1'b1;
                  end else begin
                     duty_d = duty_q + 1'b1;
                  end
               end else begin
                  if (duty_q == '0) begin
                     dir_d  = DIR_UP;
                     duty_d = duty_q + 1'b1;
                  end else begin
                     duty_d = duty_q - 1'b1;
                  end
               end
            end
         end
         default: led_next = pattern;
      endcase

      if (en) leds_d = led_next ^ LED_MASK;

      // A mode write overrides any step from a coincident tick.
      if (mode_we) begin
         mode_d = mode_e'(mode_in);
         pos_d  = '0;
         dir_d  = DIR_UP;
         duty_d = '0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctr_q  <= '0;
         mode_q <= MODE_COUNT;
         pos_q  <= '0;
         dir_q  <= DIR_UP;
         duty_q <= '0;
         tick   <= 1'b0;
         leds   <= LED_MASK;
      end else begin
         ctr_q  <= ctr_d;
         mode_q <= mode_d;
         pos_q  <= pos_d;
         dir_q  <= dir_d;
         duty_q <= duty_d;
         tick   <= tick_int;
         leds   <= leds_d;
      end
   end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with NUM_LEDS=4, CTR_WIDTH=8, TICK_SHIFT=2, PWM_BITS=2.
// A second instance with ACTIVE_LOW=1 shares all inputs to check output inversion.
module tb_led_pattern_gen;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         en;
   logic         mode_we;
   logic [1:0]   mode_in;
   logic [N-1:0] pattern;
   logic [N-1:0] leds, leds_al;
   logic         tick, tick_al;
   logic [1:0]   mode, mode_al;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic       en;
      logic       we;
      logic [1:0] mode_in;
      int         n;
      logic [3:0] exp_leds;
      logic       exp_tick;
      logic [1:0] exp_mode;
   } vec_t;

   vec_t vecs[$];

   led_pattern_gen #(
      .NUM_LEDS(N), .CTR_WIDTH(8), .TICK_SHIFT(2), .PWM_BITS(2), .ACTIVE_LOW(0)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .mode_we(mode_we), .mode_in(mode_in),
      .pattern(pattern), .leds(leds), .tick(tick), .mode(mode)
   );

   led_pattern_gen #(
      .NUM_LEDS(N), .CTR_WIDTH(8), .TICK_SHIFT(2), .PWM_BITS(2), .ACTIVE_LOW(1)
   ) dut_al (
      .clk(clk), .rst_n(rst_n), .en(en), .mode_we(mode_we), .mode_in(mode_in),
      .pattern(pattern), .leds(leds_al), .tick(tick_al), .mode(mode_al)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic e, input logic w, input logic [1:0] mi, input int n,
                               input logic [3:0] l, input logic t, input logic [1:0] m);
      vec_t v;
      v.en = e; v.we = w; v.mode_in = mi; v.n = n;
      v.exp_leds = l; v.exp_tick = t; v.exp_mode = m;
      return v;
   endfunction

   initial begin
      int duties[7];
      logic [3:0] exp_l;

      // SCAN bounce, freeze at pos=2 and resume (starts with ctr=3, mode COUNT).
      vecs.push_back(mk(1, 1, 1, 1,  4'b0000, 1, 1));
      vecs.push_back(mk(1, 0, 0, 4,  4'b0001, 1, 1));
      vecs.push_back(mk(1, 0, 0, 4,  4'b0010, 1, 1));
      vecs.push_back(mk(1, 0, 0, 4,  4'b0100, 1, 1));
      vecs.push_back(mk(1, 0, 0, 4,  4'b1000, 1, 1));
      vecs.push_back(mk(1, 0, 0, 4,  4'b0100, 1, 1));
      vecs.push_back(mk(1, 0, 0, 4,  4'b0010, 1, 1));
      vecs.push_back(mk(1, 0, 0, 4,  4'b0001, 1, 1));
      vecs.push_back(mk(1, 0, 0, 4,  4'b0010, 1, 1));
      vecs.push_back(mk(1, 0, 0, 1,  4'b0100, 0, 1));
      vecs.push_back(mk(0, 0, 0, 10, 4'b0100, 0, 1));
      vecs.push_back(mk(1, 0, 0, 2,  4'b0100, 0, 1));
      vecs.push_back(mk(1, 0, 0, 1,  4'b0100, 1, 1));
      vecs.push_back(mk(1, 0, 0, 4,  4'b1000, 1, 1));
      vecs.push_back(mk(1, 0, 0, 3,  4'b0100, 0, 1));

      rst_n = 1'b0; en = 1'b0; mode_we = 1'b0; mode_in = 2'd0; pattern = '0;
      step(); step(); step();
      check("reset leds", leds, 4'h0);
      check("reset tick", tick, 1'b0);
      check("reset mode", mode, 2'd0);
      check("reset leds_al", leds_al, 4'hF);
      rst_n = 1'b1;
      step();
      check("idle leds", leds, 4'h0);

      // COUNT: leds follow ctr[7:4] one cycle late, tick every 4 cycles, wrap at 256.
      en = 1'b1;
      for (int k = 1; k <= 259; k++) begin
         step();
         exp_l = 4'(((k - 1) % 256) >> 4);
         check($sformatf("count k%0d leds", k), leds, exp_l);
         check($sformatf("count k%0d tick", k), tick, ((k - 1) % 4) == 3);
      end

      foreach (vecs[i]) begin
         en      = vecs[i].en;
         mode_we = vecs[i].we;
         mode_in = vecs[i].mode_in;
         for (int c = 0; c < vecs[i].n; c++) begin
            step();
            mode_we = 1'b0;
            check($sformatf("vec%0d c%0d leds", i, c), leds, vecs[i].exp_leds);
            check($sformatf("vec%0d c%0d tick", i, c), tick,
                  (c == vecs[i].n - 1) ? vecs[i].exp_tick : 1'b0);
         end
         check($sformatf("vec%0d mode", i), mode, vecs[i].exp_mode);
      end

      // BREATHE written on a tick edge: duty restarts at 0 and bounces 0..3..0.
      mode_we = 1'b1; mode_in = 2'd2;
      step();
      mode_we = 1'b0;
      check("breathe wr leds", leds, 4'b0100);
      check("breathe wr tick", tick, 1'b1);
      check("breathe wr mode", mode, 2'd2);
      duties = '{0, 1, 2, 3, 2, 1, 0};
      for (int d = 0; d < 7; d++) begin
         for (int p = 0; p < 4; p++) begin
            step();
            check($sformatf("breathe d%0d p%0d leds", duties[d], p), leds,
                  (p < duties[d]) ? 4'hF : 4'h0);
            check($sformatf("breathe d%0d p%0d tick", duties[d], p), tick, p == 3);
         end
      end

      // STATIC, normal and inverted outputs.
      pattern = 4'hA; mode_we = 1'b1; mode_in = 2'd3;
      step();
      mode_we = 1'b0;
      check("static wr leds", leds, 4'hF);
      check("static wr leds_al", leds_al, 4'h0);
      check("static wr mode", mode, 2'd3);
      step();
      check("static A leds", leds, 4'hA);
      check("static A leds_al", leds_al, 4'h5);
      pattern = 4'h5;
      step();
      check("static 5 leds", leds, 4'h5);
      check("static 5 leds_al", leds_al, 4'hA);

      // Mode write coincident with tick: duty must stay 0 for a full tick period.
      mode_we = 1'b1; mode_in = 2'd2;
      step();
      mode_we = 1'b0;
      check("prio wr leds", leds, 4'h5);
      check("prio wr tick", tick, 1'b1);
      for (int p = 0; p < 4; p++) begin
         step();
         check($sformatf("prio p%0d leds", p), leds, 4'h0);
         check($sformatf("prio p%0d tick", p), tick, p == 3);
      end
      step();
      check("prio duty1 leds", leds, 4'hF);
      check("prio duty1 mode", mode, 2'd2);

      // Asynchronous reset mid-cycle.
      #2;
      rst_n = 1'b0;
      #1;
      check("async leds", leds, 4'h0);
      check("async mode", mode, 2'd0);
      check("async tick", tick, 1'b0);
      check("async leds_al", leds_al, 4'hF);
      step();
      check("held rst leds", leds, 4'h0);
      rst_n = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         step();
         check($sformatf("post rst k%0d leds", k), leds, 4'h0);
         check($sformatf("post rst k%0d tick", k), tick, k == 4);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
